// File: rtl/zx_kbd_matrix_if.sv
// Bus bundle between the host side (ULA / PS/2 receiver) and the keyboard
// matrix generator.
interface zx_kbd_matrix_if #(parameter int COLS = 5);
  logic [15:0]     A;
  logic [COLS-1:0] key_row;
  logic [7:0]      scan_code;
  logic            scan_code_ready;
  logic            scan_code_error;
  logic            status_clr;
  logic            pressed;
  logic            overflow;
  logic            overrun;

  modport master (
    output A, scan_code, scan_code_ready, scan_code_error, status_clr,
    input  key_row, pressed, overflow, overrun
  );

  modport slave (
    input  A, scan_code, scan_code_ready, scan_code_error, status_clr,
    output key_row, pressed, overflow, overrun
  );
endinterface

// File: rtl/zx_kbd_matrix.sv
// PS/2 set-2 scan codes to ZX Spectrum keyboard matrix. Every held PS/2 key
// owns a slot remembering the matrix positions it asserted; each matrix
// position is reference-counted so composite keys overlap cleanly.
//
// state  | meaning
// IDLE   | waiting for a byte; handles E0/F0/E1 prefixes and Pause skipping
// DECODE | map {ext, code, shift} to positions, search the slot table
// COMMIT | allocate/free a slot and adjust the position counters
module zx_kbd_matrix #(
  parameter int ROWS  = 8,
  parameter int COLS  = 5,
  parameter int SLOTS = 8,
  parameter int CNT_W = 4
) (
  input logic            clk,
  input logic            reset,
  zx_kbd_matrix_if.slave bus
);
  localparam int NPOS  = ROWS * COLS;
  localparam int POS_W = $clog2(NPOS + 1);
  localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [POS_W-1:0] NONE = '1;

  typedef enum logic [1:0] {IDLE, DECODE, COMMIT} state_t;

  state_t           state_q, state_d;
  logic             ext_q, ext_d, rel_q, rel_d, shift_q, shift_d;
  logic [2:0]       skip_q, skip_d;
  logic             lat_ext_q, lat_ext_d, lat_rel_q, lat_rel_d;
  logic [7:0]       lat_code_q, lat_code_d;
  logic [POS_W-1:0] pos_a_q, pos_a_d, pos_b_q, pos_b_d;
  logic             match_q, match_d, full_q, full_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d, free_idx_q, free_idx_d;
  logic [SLOTS-1:0] slot_vld_q, slot_vld_d, slot_ext_q, slot_ext_d;
  logic [7:0]       slot_code_q [SLOTS];
  logic [7:0]       slot_code_d [SLOTS];
  logic [POS_W-1:0] slot_pa_q [SLOTS];
  logic [POS_W-1:0] slot_pa_d [SLOTS];
  logic [POS_W-1:0] slot_pb_q [SLOTS];
  logic [POS_W-1:0] slot_pb_d [SLOTS];
  logic [CNT_W-1:0] cnt_q [NPOS];
  logic [CNT_W-1:0] cnt_d [NPOS];
  logic             pressed_q, pressed_d, overflow_q, overflow_d, overrun_q, overrun_d;
  logic             ovf_set, ovr_set;
  logic [POS_W-1:0] rel_a, rel_b;
  logic             unused_a;

  assign unused_a = ^bus.A[7:0];

  function automatic logic [POS_W-1:0] pos(input int r, input int c);
    if (r < ROWS && c < COLS) return POS_W'(r * COLS + c);
    return NONE;
  endfunction

  // Standard Spectrum layout; symbols are SYM plus a key chosen by PC shift.
  function automatic void key_map(input logic ext, input logic [7:0] code, input logic shf,
                                  output logic [POS_W-1:0] a, output logic [POS_W-1:0] b);
    a = NONE;
    b = NONE;
    if (ext) begin
      case (code)
        8'h14: a = pos(0, 0);
        8'h11: a = pos(7, 1);
        8'h5A: a = pos(6, 0);
        8'h6B: begin a = pos(0, 0); b = pos(3, 4); end
        8'h72: begin a = pos(0, 0); b = pos(4, 4); end
        8'h75: begin a = pos(0, 0); b = pos(4, 3); end
        8'h74: begin a = pos(0, 0); b = pos(4, 2); end
        default: ;
      endcase
    end else begin
      case (code)
        8'h14: a = pos(0, 0);  8'h1A: a = pos(0, 1);  8'h22: a = pos(0, 2);
        8'h21: a = pos(0, 3);  8'h2A: a = pos(0, 4);
        8'h1C: a = pos(1, 0);  8'h1B: a = pos(1, 1);  8'h23: a = pos(1, 2);
        8'h2B: a = pos(1, 3);  8'h34: a = pos(1, 4);
        8'h15: a = pos(2, 0);  8'h1D: a = pos(2, 1);  8'h24: a = pos(2, 2);
        8'h2D: a = pos(2, 3);  8'h2C: a = pos(2, 4);
        8'h16: a = pos(3, 0);  8'h1E: a = pos(3, 1);  8'h26: a = pos(3, 2);
        8'h25: a = pos(3, 3);  8'h2E: a = pos(3, 4);
        8'h45: a = pos(4, 0);  8'h46: a = pos(4, 1);  8'h3E: a = pos(4, 2);
        8'h3D: a = pos(4, 3);  8'h36: a = pos(4, 4);
        8'h4D: a = pos(5, 0);  8'h44: a = pos(5, 1);  8'h43: a = pos(5, 2);
        8'h3C: a = pos(5, 3);  8'h35: a = pos(5, 4);
        8'h5A: a = pos(6, 0);  8'h4B: a = pos(6, 1);  8'h42: a = pos(6, 2);
        8'h3B: a = pos(6, 3);  8'h33: a = pos(6, 4);
        8'h29: a = pos(7, 0);  8'h11: a = pos(7, 1);  8'h3A: a = pos(7, 2);
        8'h31: a = pos(7, 3);  8'h32: a = pos(7, 4);
        8'h66: begin a = pos(0, 0); b = pos(4, 0); end
        8'h76: begin a = pos(0, 0); b = pos(7, 0); end
        8'h4E: begin a = pos(7, 1); b = shf ? pos(4, 0) : pos(6, 3); end
        8'h55: begin a = pos(7, 1); b = shf ? pos(6, 2) : pos(6, 1); end
        8'h4C: begin a = pos(7, 1); b = shf ? pos(0, 1) : pos(5, 1); end
        8'h52: begin a = pos(7, 1); b = shf ? pos(5, 0) : pos(4, 3); end
        8'h41: begin a = pos(7, 1); b = shf ? pos(2, 3) : pos(7, 3); end
        8'h49: begin a = pos(7, 1); b = shf ? pos(2, 4) : pos(7, 2); end
        8'h4A: begin a = pos(7, 1); b = shf ? pos(0, 3) : pos(0, 4); end
        default: ;
      endcase
    end
  endfunction

  // Next-state logic for the FSM, slot table, counters and status bits.
  always_comb begin
    state_d = state_q;  ext_d = ext_q;  rel_d = rel_q;  shift_d = shift_q;  skip_d = skip_q;
    lat_ext_d = lat_ext_q;  lat_rel_d = lat_rel_q;  lat_code_d = lat_code_q;
    pos_a_d = pos_a_q;  pos_b_d = pos_b_q;  match_d = match_q;  full_d = full_q;
    match_idx_d = match_idx_q;  free_idx_d = free_idx_q;
    slot_vld_d = slot_vld_q;  slot_ext_d = slot_ext_q;
    slot_code_d = slot_code_q;  slot_pa_d = slot_pa_q;  slot_pb_d = slot_pb_q;
    cnt_d = cnt_q;
    ovf_set = 1'b0;
    ovr_set = 1'b0;
    rel_a = slot_pa_q[match_idx_q];
    rel_b = slot_pb_q[match_idx_q];
    if (bus.scan_code_error) begin
      state_d = IDLE;  ext_d = 1'b0;  rel_d = 1'b0;  shift_d = 1'b0;  skip_d = '0;
      slot_vld_d = '0;
      for (int i = 0; i < NPOS; i++) cnt_d[i] = '0;
    end else begin
      if (bus.scan_code_ready && state_q != IDLE) ovr_set = 1'b1;
      case (state_q)
        IDLE: if (bus.scan_code_ready) begin
          if (skip_q != '0)                  skip_d = skip_q - 3'd1;
          else if (bus.scan_code == 8'hE1)   skip_d = 3'd7;
          else if (bus.scan_code == 8'hE0)   ext_d = 1'b1;
          else if (bus.scan_code == 8'hF0)   rel_d = 1'b1;
          else begin
            lat_ext_d  = ext_q;
            lat_rel_d  = rel_q;
            lat_code_d = bus.scan_code;
            ext_d      = 1'b0;
            rel_d      = 1'b0;
            state_d    = DECODE;
          end
        end
        DECODE: begin
          if (!lat_ext_q && (lat_code_q == 8'h12 || lat_code_q == 8'h59)) begin
            shift_d = !lat_rel_q;
            state_d = IDLE;
          end else begin
            key_map(lat_ext_q, lat_code_q, shift_q, pos_a_d, pos_b_d);
            match_d = 1'b0;  match_idx_d = '0;  full_d = 1'b1;  free_idx_d = '0;
            // Descending scan so the lowest free slot wins.
            for (int i = SLOTS - 1; i >= 0; i--) begin
              if (slot_vld_q[i] && slot_ext_q[i] == lat_ext_q && slot_code_q[i] == lat_code_q) begin
                match_d     = 1'b1;
                match_idx_d = IDX_W'(i);
              end
              if (!slot_vld_q[i]) begin
                full_d     = 1'b0;
                free_idx_d = IDX_W'(i);
              end
            end
            state_d = COMMIT;
          end
        end
        COMMIT: begin
          state_d = IDLE;
          if (!lat_rel_q && !match_q && pos_a_q != NONE) begin
            if (full_q) ovf_set = 1'b1;
            else begin
              slot_vld_d[free_idx_q]  = 1'b1;
              slot_ext_d[free_idx_q]  = lat_ext_q;
              slot_code_d[free_idx_q] = lat_code_q;
              slot_pa_d[free_idx_q]   = pos_a_q;
              slot_pb_d[free_idx_q]   = pos_b_q;
              for (int i = 0; i < NPOS; i++)
                if (POS_W'(i) == pos_a_q || POS_W'(i) == pos_b_q) cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
          end else if (lat_rel_q && match_q) begin
            slot_vld_d[match_idx_q] = 1'b0;
            for (int i = 0; i < NPOS; i++)
              if ((POS_W'(i) == rel_a || POS_W'(i) == rel_b) && cnt_q[i] != '0)
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    overflow_d = ovf_set | (overflow_q & ~bus.status_clr);
    overrun_d  = ovr_set | (overrun_q & ~bus.status_clr);
    pressed_d  = 1'b0;
    for (int i = 0; i < NPOS; i++) if (cnt_d[i] != '0) pressed_d = 1'b1;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;  ext_q <= 1'b0;  rel_q <= 1'b0;  shift_q <= 1'b0;  skip_q <= '0;
      lat_ext_q <= 1'b0;  lat_rel_q <= 1'b0;  lat_code_q <= '0;
      pos_a_q <= NONE;  pos_b_q <= NONE;  match_q <= 1'b0;  full_q <= 1'b0;
      match_idx_q <= '0;  free_idx_q <= '0;
      slot_vld_q <= '0;  slot_ext_q <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        slot_code_q[i] <= '0;
        slot_pa_q[i]   <= NONE;
        slot_pb_q[i]   <= NONE;
      end
      for (int i = 0; i < NPOS; i++) cnt_q[i] <= '0;
      pressed_q <= 1'b0;  overflow_q <= 1'b0;  overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;  ext_q <= ext_d;  rel_q <= rel_d;  shift_q <= shift_d;  skip_q <= skip_d;
      lat_ext_q <= lat_ext_d;  lat_rel_q <= lat_rel_d;  lat_code_q <= lat_code_d;
      pos_a_q <= pos_a_d;  pos_b_q <= pos_b_d;  match_q <= match_d;  full_q <= full_d;
      match_idx_q <= match_idx_d;  free_idx_q <= free_idx_d;
      slot_vld_q <= slot_vld_d;  slot_ext_q <= slot_ext_d;
      slot_code_q <= slot_code_d;  slot_pa_q <= slot_pa_d;  slot_pb_q <= slot_pb_d;
      cnt_q <= cnt_d;
      pressed_q <= pressed_d;  overflow_q <= overflow_d;  overrun_q <= overrun_d;
    end
  end

  // Row read: AND of every row whose address line is low.
  always_comb begin
    bus.key_row = '1;
    for (int r = 0; r < ROWS; r++)
      if (!bus.A[8 + r])
        for (int c = 0; c < COLS; c++)
          if (cnt_q[r * COLS + c] != '0) bus.key_row[c] = 1'b0;
  end

  assign bus.pressed  = pressed_q;
  assign bus.overflow = overflow_q;
  assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_zx_kbd_matrix.sv
// Directed bench for zx_kbd_matrix: stimulus pushes hand-computed expected
// matrix/status values into a queue; a negedge monitor pops and compares.
module tb_zx_kbd_matrix;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  zx_kbd_matrix_if #(.COLS(5)) bus ();

  zx_kbd_matrix #(.ROWS(8), .COLS(5), .SLOTS(8), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [4:0] row;
    logic       pr;
    logic       ovf;
    logic       ovr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  logic exp_ovf = 1'b0;
  logic exp_ovr = 1'b0;

  // Monitor: one expectation is consumed per sampled cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (bus.key_row !== mon_e.row || bus.pressed !== mon_e.pr ||
          bus.overflow !== mon_e.ovf || bus.overrun !== mon_e.ovr) begin
        failures++;
        $display("FAIL %s: got key_row=%b pressed=%b overflow=%b overrun=%b, want key_row=%b pressed=%b overflow=%b overrun=%b",
                 mon_e.name, bus.key_row, bus.pressed, bus.overflow, bus.overrun,
                 mon_e.row, mon_e.pr, mon_e.ovf, mon_e.ovr);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_byte(input logic [7:0] b);
    bus.scan_code = b;
    bus.scan_code_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.scan_code_ready = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    pulse_byte(b);
    idle(3);
  endtask

  task automatic pulse_error();
    bus.scan_code_error = 1'b1;
    @(posedge clk);
    #1;
    bus.scan_code_error = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.status_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.status_clr = 1'b0;
  endtask

  task automatic check(input string name, input logic [15:0] a, input logic [4:0] row, input logic pr);
    exp_t e;
    bus.A  = a;
    e.name = name;
    e.row  = row;
    e.pr   = pr;
    e.ovf  = exp_ovf;
    e.ovr  = exp_ovr;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nine [9];
    logic [7:0] pause_seq [8];
    nine      = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B};
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    bus.A = 16'hFFFF;
    bus.scan_code = 8'h00;
    bus.scan_code_ready = 1'b0;
    bus.scan_code_error = 1'b0;
    bus.status_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    check("rst_fefe", 16'hFEFE, 5'b11111, 1'b0);
    check("rst_all",  16'h00FE, 5'b11111, 1'b0);

    // Z press latency: new value first visible three cycles after the strobe.
    bus.A = 16'hFEFE;
    pulse_byte(8'h1A);
    check("z_n1", 16'hFEFE, 5'b11111, 1'b0);
    check("z_n2", 16'hFEFE, 5'b11111, 1'b0);
    check("z_n3", 16'hFEFE, 5'b11101, 1'b1);
    send(8'hF0); send(8'h1A);
    check("z_rel", 16'hFEFE, 5'b11111, 1'b0);

    // Overlapping arrows share CAPS.
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'h74);
    check("arr_fe", 16'hFEFE, 5'b11110, 1'b1);
    check("arr_f7", 16'hF7FE, 5'b01111, 1'b1);
    check("arr_ef", 16'hEFFE, 5'b11011, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("lrel_fe", 16'hFEFE, 5'b11110, 1'b1);
    check("lrel_f7", 16'hF7FE, 5'b11111, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("rrel_all", 16'h00FE, 5'b11111, 1'b0);

    // Shifted symbol, released after shift is dropped.
    send(8'h12); send(8'h4C);
    check("sym_7f", 16'h7FFE, 5'b11101, 1'b1);
    check("sym_fe", 16'hFEFE, 5'b11101, 1'b1);
    check("sym_df", 16'hDFFE, 5'b11111, 1'b1);
    send(8'hF0); send(8'h12);
    send(8'hF0); send(8'h4C);
    check("sym_rel", 16'h00FE, 5'b11111, 1'b0);

    // Multi-row AND: Q, W, SPACE held.
    send(8'h15); send(8'h1D); send(8'h29);
    check("rows_7c", 16'h7CFE, 5'b11110, 1'b1);
    check("rows_7b", 16'h7BFE, 5'b11100, 1'b1);
    check("rows_fb", 16'hFBFE, 5'b11100, 1'b1);
    check("rows_ff", 16'hFFFF, 5'b11111, 1'b1);
    send(8'hF0); send(8'h15);
    send(8'hF0); send(8'h1D);
    send(8'hF0); send(8'h29);
    check("rows_rel", 16'h00FE, 5'b11111, 1'b0);

    // Slot table overflow, typematic repeat, status clear.
    for (int i = 0; i < 9; i++) send(nine[i]);
    exp_ovf = 1'b1;
    check("ovf_r1", 16'hFDFE, 5'b00000, 1'b1);
    check("ovf_r6", 16'hBFFE, 5'b00011, 1'b1);
    repeat (5) send(8'h1C);
    check("rep_r1", 16'hFDFE, 5'b00000, 1'b1);
    send(8'hF0); send(8'h1C);
    check("arel_r1", 16'hFDFE, 5'b00001, 1'b1);
    send(8'h4B);
    check("l_r6", 16'hBFFE, 5'b00001, 1'b1);
    pulse_clr();
    exp_ovf = 1'b0;
    check("ovf_clr", 16'hFFFF, 5'b11111, 1'b1);
    pulse_error();
    check("err_clean", 16'h00FE, 5'b11111, 1'b0);

    // UP held, overrun, then receive error.
    send(8'hE0); send(8'h75);
    check("up_fe", 16'hFEFE, 5'b11110, 1'b1);
    check("up_ef", 16'hEFFE, 5'b10111, 1'b1);
    pulse_byte(8'h1A);
    pulse_byte(8'h1B);
    idle(3);
    exp_ovr = 1'b1;
    check("ovr_fe", 16'hFEFE, 5'b11100, 1'b1);
    check("ovr_fd", 16'hFDFE, 5'b11111, 1'b1);
    bus.A = 16'hFEFE;
    pulse_error();
    check("err_fe", 16'hFEFE, 5'b11111, 1'b0);
    check("err_ef", 16'hEFFE, 5'b11111, 1'b0);
    send(8'hE0);
    pulse_error();
    idle(1);
    send(8'h75);
    check("err_ext", 16'h00FE, 5'b11111, 1'b0);
    pulse_clr();
    exp_ovr = 1'b0;
    check("ovr_clr", 16'hFFFF, 5'b11111, 1'b0);

    // Pause sequence is swallowed; the next key after it works.
    for (int i = 0; i < 8; i++) send(pause_seq[i]);
    check("pause_all", 16'h00FE, 5'b11111, 1'b0);
    send(8'h1A);
    check("post_pause", 16'hFEFE, 5'b11101, 1'b1);

    idle(2);
    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
